// File: rtl/key_debouncer_if.sv
// key_debouncer_if: bundles the raw pushbutton inputs with the debounced key event outputs.
// Latency: none; this is only wiring. Timing is set by the module on the slave side.
// Backpressure: none. The outputs are free-running levels and one-cycle strobes.
// Ports: KEY (raw, active-low); key_held (debounced level); key_press, key_release, key_repeat (one-cycle pulses).
// Modports: slave = debouncer side (KEY in, events out); master = consumer side (drives KEY, reads events).
interface key_debouncer_if;
  logic [3:0] KEY;
  logic [3:0] key_held;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;

  modport slave (
    input  KEY,
    output key_held,
    output key_press,
    output key_release,
    output key_repeat
  );

  modport master (
    output KEY,
    input  key_held,
    input  key_press,
    input  key_release,
    input  key_repeat
  );
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes and debounces four active-low pushbuttons, each in its own independent lane.
// Latency: a KEY level held for DEBOUNCE_CYCLES shows on the registered outputs DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none. Each lane accepts at most one event per DEBOUNCE_CYCLES cycles.
// Ports: CLOCK_50 (sole clock); reset (synchronous, active-high); kb (slave modport).
//        kb.KEY: raw, active-low. kb.key_held: debounced level, 1 = pressed.
//        kb.key_press, kb.key_release, kb.key_repeat: one-cycle pulses, mutually exclusive per lane.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  key_debouncer_if.slave kb
);

  localparam int unsigned NK = 4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } lane_state_e;

  // Two-flop synchronizer per key. Both stages idle at 1 (released).
  logic [NK-1:0] sync1_q, sync1_d;
  logic [NK-1:0] sync2_q, sync2_d;

  lane_state_e      state_q [NK];
  lane_state_e      state_d [NK];
  logic [CNT_W-1:0] dcnt_q  [NK];
  logic [CNT_W-1:0] dcnt_d  [NK];
  logic [CNT_W-1:0] rcnt_q  [NK];
  logic [CNT_W-1:0] rcnt_d  [NK];
  // Set while the lane is still waiting for its first repeat, which uses the longer REPEAT_DELAY interval.
  logic [NK-1:0]    first_q, first_d;

  logic [NK-1:0] held_q,    held_d;
  logic [NK-1:0] press_q,   press_d;
  logic [NK-1:0] release_q, release_d;
  logic [NK-1:0] repeat_q,  repeat_d;

  // Set on edges where the repeat schedule moves forward.
  logic [NK-1:0] adv;

  always_comb begin
    sync1_d = kb.KEY;
    sync2_d = sync1_q;
  end

  always_comb begin
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    held_d    = '0;
    adv       = '0;
    first_d   = first_q;
    for (int i = 0; i < NK; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      rcnt_d[i]  = rcnt_q[i];

      case (state_q[i])
        RELEASED: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_PEND;
            dcnt_d[i]  = CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASED;
            dcnt_d[i]  = CNT_ZERO;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i] = HELD;
            dcnt_d[i]  = CNT_ZERO;
            rcnt_d[i]  = CNT_ZERO;
            first_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (sync2_q[i]) begin
            // The repeat counter freezes while a release is being qualified.
            state_d[i] = RELEASE_PEND;
            dcnt_d[i]  = CNT_ONE;
          end else begin
            adv[i] = 1'b1;
          end
        end
        RELEASE_PEND: begin
          if (!sync2_q[i]) begin
            // Glitch rejected. The schedule resumes on this edge, so the cadence
            // slips by exactly the number of cycles the release was pending.
            state_d[i] = HELD;
            dcnt_d[i]  = CNT_ZERO;
            adv[i]     = 1'b1;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i]   = RELEASED;
            dcnt_d[i]    = CNT_ZERO;
            release_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = RELEASED;
          dcnt_d[i]  = CNT_ZERO;
          rcnt_d[i]  = CNT_ZERO;
        end
      endcase

      if (adv[i]) begin
        if (rcnt_q[i] == (first_q[i] ? RD_LAST : RP_LAST)) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = CNT_ZERO;
          first_d[i]  = 1'b0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + CNT_ONE;
        end
      end

      // Outputs come from the next state, so the held edge and its pulse leave the same flop stage together.
      held_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_PEND);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      first_q   <= '0;
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < NK; i++) begin
        state_q[i] <= RELEASED;
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      first_q   <= first_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < NK; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  assign kb.key_held    = held_q;
  assign kb.key_press   = press_q;
  assign kb.key_release = release_q;
  assign kb.key_repeat  = repeat_q;

endmodule
